// File: rtl/pwm_cfg_scheduler_pkg.sv
// Shared constants and FSM encoding for the PWM configuration scheduler.
package pwm_cfg_scheduler_pkg;

  // PWM period counter width (one period = 256 counter ticks)
  localparam int PWM_CNT_W = 8;

  // Number of configuration registers held in shadow/committed banks
  localparam int NUM_REGS = 5;

  // Register map
  localparam int ADDR_EN_UO   = 0;
  localparam int ADDR_EN_UIO  = 1;
  localparam int ADDR_PWM_UO  = 2;
  localparam int ADDR_PWM_UIO = 3;
  localparam int ADDR_DUTY    = 4;

  // Scheduler FSM: IDLE = shadow matches committed, DIRTY = commit waiting
  // for the next period boundary, COMMIT = one-cycle copy shadow -> committed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRTY  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_cfg_scheduler_timebase.sv
// PWM timebase: prescaler, 8-bit period counter and registered wrap pulse.
module pwm_timebase
  import pwm_cfg_scheduler_pkg::*;
#(
  parameter int PRESCALE = 13  // clocks per counter tick, must be >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_CNT_W-1:0] CNT_LAST = '1;

  logic [PS_W-1:0]      presc_q, presc_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ps_q, ps_d;
  logic                 tick;

  // Next-state: prescaler wraps on tick, counter advances on tick, and the
  // wrap pulse is registered so it lines up with the first cycle of cnt == 0.
  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    cnt_d   = tick ? cnt_q + PWM_CNT_W'(1) : cnt_q;
    ps_d    = tick && (cnt_q == CNT_LAST);
  end

  // Timebase state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_cnt      = cnt_q;
  assign period_start = ps_q;

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration scheduler: SPI writes land in shadow registers and are
// committed atomically one cycle after a PWM period boundary, so duty/enable
// changes never glitch mid-period.
module pwm_cfg_scheduler
  import pwm_cfg_scheduler_pkg::*;
#(
  parameter int PRESCALE = 13,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_uo,
  output logic [7:0] en_uio,
  output logic [7:0] pwm_en_uo,
  output logic [7:0] pwm_en_uio,
  output logic [7:0] duty,
  output logic [7:0] pwm_cnt,
  output logic       period_start,
  output logic       pwm_level,
  output logic       pending,
  output logic       bad_addr
);

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  state_e state_q, state_d;
  logic [NUM_REGS-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0][7:0] com_q, com_d;
  logic bad_q, bad_d;
  logic wr_fire, addr_ok;

  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start)
  );

  assign wr_ready = (state_q != COMMIT);
  assign pending  = (state_q != IDLE);
  assign wr_fire  = wr_valid && wr_ready;
  assign addr_ok  = (wr_addr <= MAX_ADDR_L);

  // Shadow update and sticky bad-address flag; out-of-range writes are
  // accepted but dropped.
  always_comb begin
    shadow_d = shadow_q;
    bad_d    = bad_q | (wr_fire & ~addr_ok);
    if (wr_fire && addr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == 7'(i)) shadow_d[i] = wr_data;
      end
    end
  end

  // FSM next-state and commit copy. COMMIT copies shadow_q, which already
  // holds any write accepted in the period_start cycle that led here.
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    case (state_q)
      IDLE:    if (wr_fire && addr_ok) state_d = DIRTY;
      DIRTY:   if (period_start)       state_d = COMMIT;
      COMMIT: begin
        com_d   = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state registers; reset discards any uncommitted shadow data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      com_q    <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      com_q    <= com_d;
      bad_q    <= bad_d;
    end
  end

  assign en_uo      = com_q[ADDR_EN_UO];
  assign en_uio     = com_q[ADDR_EN_UIO];
  assign pwm_en_uo  = com_q[ADDR_PWM_UO];
  assign pwm_en_uio = com_q[ADDR_PWM_UIO];
  assign duty       = com_q[ADDR_DUTY];
  assign bad_addr   = bad_q;

  // PWM waveform from committed duty; 0xFF means constantly high
  always_comb begin
    pwm_level = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);
  end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Scoreboard bench: stimulus pushes the committed register set expected after
// the next period boundary; a monitor pops it once the commit has landed.
module tb_pwm_cfg_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] en_uo, en_uio, pwm_en_uo, pwm_en_uio, duty, pwm_cnt;
  logic       period_start, pwm_level, pending, bad_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] en_uo, en_uio, pwm_uo, pwm_uio, duty;
  } exp_t;
  exp_t exp_q[$];

  pwm_cfg_scheduler #(.PRESCALE(13), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .en_uo(en_uo), .en_uio(en_uio),
    .pwm_en_uo(pwm_en_uo), .pwm_en_uio(pwm_en_uio), .duty(duty),
    .pwm_cnt(pwm_cnt), .period_start(period_start), .pwm_level(pwm_level),
    .pending(pending), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic push(input logic [7:0] a, b, c, d, e);
    exp_t x;
    x.en_uo = a; x.en_uio = b; x.pwm_uo = c; x.pwm_uio = d; x.duty = e;
    exp_q.push_back(x);
  endtask

  // Count clocks until pwm_cnt == v (returns at posedge + 1)
  task automatic wait_cnt(input logic [7:0] v, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (pwm_cnt == v) break;
      if (n > 4000) begin timeout("wait_cnt"); break; end
    end
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (period_start) break;
      if (n > 4000) begin timeout("wait_period_start"); break; end
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1; n++;
      if (n > 4000) begin timeout("wait_commit"); break; end
    end
  endtask

  // Holds the write until accepted; reports cycles stalled on wr_ready
  task automatic wr(input logic [6:0] a, input logic [7:0] d, output int stalls);
    logic acc;
    stalls = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    while (1) begin
      @(negedge clk); acc = wr_ready;
      @(posedge clk); #1;
      if (acc) break;
      stalls++;
      if (stalls > 20) begin timeout("write_accept"); break; end
    end
    wr_valid = 1'b0;
  endtask

  // Monitor: two cycles after each boundary the commit has landed
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && period_start) begin
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("sb_en_uo",      en_uo,      x.en_uo);
          check("sb_en_uio",     en_uio,     x.en_uio);
          check("sb_pwm_en_uo",  pwm_en_uo,  x.pwm_uo);
          check("sb_pwm_en_uio", pwm_en_uio, x.pwm_uio);
          check("sb_duty",       duty,       x.duty);
          check("sb_pending",    pending,    1'b0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, st;
    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en_uo", en_uo, 0);
    check("rst_duty", duty, 0);
    check("rst_pwm_cnt", pwm_cnt, 0);
    check("rst_period_start", period_start, 0);
    check("rst_pwm_level", pwm_level, 0);
    check("rst_pending", pending, 0);
    check("rst_bad_addr", bad_addr, 0);
    check("rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // ---- timebase: tick every 13 clocks, wrap at 256*13 = 3328
    wait_cnt(8'd1, n); check("tick_first", n, 13);
    wait_cnt(8'd2, n); check("tick_second", n, 13);
    wait_ps(n);        check("period_len", n, 3328 - 26);
    check("wrap_cnt_zero", pwm_cnt, 0);
    @(posedge clk); #1;
    check("period_start_one_cycle", period_start, 0);

    // ---- deferred commit
    wait_cnt(8'd10, n);
    wr(7'd4, 8'h80, st);
    @(negedge clk);
    check("defer_pending", pending, 1);
    check("defer_duty_held", duty, 8'h00);
    push(8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    wait_cnt(8'd200, n);
    check("defer_duty_late", duty, 8'h00);
    wait_empty();
    check("defer_level_0", pwm_level, 1);
    wait_cnt(8'd127, n); check("defer_level_127", pwm_level, 1);
    wait_cnt(8'd128, n); check("defer_level_128", pwm_level, 0);
    wait_cnt(8'd255, n); check("defer_level_255", pwm_level, 0);

    // ---- boundary collision
    wait_cnt(8'd50, n);
    wr(7'd3, 8'h5A, st);
    push(8'h00, 8'h00, 8'h00, 8'h5A, 8'h40);
    wait_ps(n);
    wr(7'd4, 8'h40, st);
    check("coll_no_stall", st, 0);
    wr(7'd0, 8'h11, st);
    check("coll_stall_in_commit", st, 1);
    @(negedge clk);
    check("coll_pending_after", pending, 1);
    check("coll_exp_drained", exp_q.size(), 0);
    wait_cnt(8'd63, n); check("coll_level_63", pwm_level, 1);
    wait_cnt(8'd64, n); check("coll_level_64", pwm_level, 0);

    // ---- last write wins, multi-register commit
    wr(7'd0, 8'hFF, st);
    wr(7'd4, 8'h10, st);
    wr(7'd4, 8'hFF, st);
    push(8'hFF, 8'h00, 8'h00, 8'h5A, 8'hFF);
    wait_empty();
    check("full_level_0", pwm_level, 1);
    wait_cnt(8'd128, n); check("full_level_128", pwm_level, 1);
    wait_cnt(8'd255, n); check("full_level_255", pwm_level, 1);

    // ---- bad address, then same-value write still marks dirty
    wait_cnt(8'd5, n);
    wr(7'd5, 8'hAA, st);
    @(negedge clk);
    check("bad_flag", bad_addr, 1);
    check("bad_pending", pending, 0);
    check("bad_duty_kept", duty, 8'hFF);
    wr(7'd4, 8'hFF, st);
    @(negedge clk);
    check("same_val_pending", pending, 1);
    push(8'hFF, 8'h00, 8'h00, 8'h5A, 8'hFF);
    wait_empty();
    check("bad_sticky", bad_addr, 1);

    // ---- reset mid-DIRTY
    wait_cnt(8'd20, n);
    wr(7'd4, 8'h20, st);
    @(negedge clk);
    check("rmid_pending", pending, 1);
    rst = 1'b1;
    #1;
    check("rmid_async_pending", pending, 0);
    check("rmid_duty", duty, 0);
    check("rmid_en_uo", en_uo, 0);
    check("rmid_bad_clr", bad_addr, 0);
    check("rmid_cnt", pwm_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_empty();
    check("rmid_pending_after", pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
